// File: rtl/riscv_pkg.sv
// Shared RV32 constants: datapath width, reset vector, canonical NOP and base opcodes.
package riscv_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode valid/ready handshake.
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_rdata, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it and wins over a same-cycle push.
module fetch_fifo import riscv_pkg::*; #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle imem issue with epoch tagging, prefetch FIFO, redirects.
// Define FETCH_PERF_EN to build the fetch_cnt/flush_cnt performance counters.
module fetch_unit import riscv_pkg::*; #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]    pc, inflight_pc, target, addr;
  logic               inflight, inflight_epoch, epoch;
  logic               pop, push, empty, req;
  logic [CW-1:0]      count;
  logic [CW:0]        occ;
  logic [XLEN+31:0]   head;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // Redirect suppresses the handshake so a stale head is never consumed.
  assign bus.if_valid = !empty && !redirect_valid;
  assign pop          = bus.if_valid && bus.if_ready;

  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign occ  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign req  = rst_n && (redirect_valid || (occ < (CW+1)'(DEPTH)));
  assign addr = redirect_valid ? target : pc;
  assign push = inflight && (inflight_epoch == epoch);

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.if_pc       = head[XLEN+31:32];
  assign bus.if_instr    = head[31:0];
  assign bus.if_pc_plus4 = bus.if_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight       <= req;
      inflight_epoch <= epoch ^ redirect_valid;
      epoch          <= epoch ^ redirect_valid;
      if (req) begin
        pc          <= addr + XLEN'(4);
        inflight_pc <= addr;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN + 32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({inflight_pc, bus.imem_rdata}),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(pop);
      flush_cnt <= flush_cnt + 32'(redirect_valid);
    end
  end
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall, redirects, wrap and mid-stream reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_cnt, flush_cnt;
  int          n_cmp = 0, n_bad = 0;
  int unsigned exp_fetch = 0, exp_flush = 0;

  fetch_unit_if #(.XLEN(32)) bus();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  function automatic logic [31:0] perf(input int unsigned v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'h0 + 0 * v;
`endif
  endfunction

  // Synchronous memory: data for this cycle's request appears next cycle.
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? word(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.if_valid); end
    n_cmp++; if (fetch_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_fetch_cnt got %0d want 0", fetch_cnt); end
    n_cmp++; if (flush_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_flush_cnt got %0d want 0", flush_cnt); end
  endtask

  task automatic test_stream;
    rst_n = 1'b1; bus.if_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL c0_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL c0_valid got %b want 0", bus.if_valid); end
    tick; #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL c1_req got %b/%h want 1/4", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL c1_valid got %b want 0", bus.if_valid); end
    tick;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4*k)) begin n_bad++; $display("FAIL stream_pc got %b/%h want 1/%h", bus.if_valid, bus.if_pc, 32'(4*k)); end
      n_cmp++; if (bus.if_instr !== word(32'(4*k))) begin n_bad++; $display("FAIL stream_instr got %h want %h", bus.if_instr, word(32'(4*k))); end
      n_cmp++; if (bus.if_pc_plus4 !== 32'(4*k+4)) begin n_bad++; $display("FAIL stream_pc4 got %h want %h", bus.if_pc_plus4, 32'(4*k+4)); end
      exp_fetch++;
      tick;
    end
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr got %b/%h want 1/100", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (fetch_cnt !== perf(exp_fetch)) begin n_bad++; $display("FAIL redir_fetch_cnt got %0d want %0d", fetch_cnt, perf(exp_fetch)); end
    tick; exp_flush++; redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_gap got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h104) begin n_bad++; $display("FAIL redir_next_addr got %h want 104", bus.imem_addr); end
    n_cmp++; if (fetch_cnt !== perf(exp_fetch)) begin n_bad++; $display("FAIL redir_fetch_hold got %0d want %0d", fetch_cnt, perf(exp_fetch)); end
    n_cmp++; if (flush_cnt !== perf(exp_flush)) begin n_bad++; $display("FAIL redir_flush_cnt got %0d want %0d", flush_cnt, perf(exp_flush)); end
    tick;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 + 32'(4*k)) begin n_bad++; $display("FAIL redir_pc got %b/%h want 1/%h", bus.if_valid, bus.if_pc, 32'h100 + 32'(4*k)); end
      n_cmp++; if (bus.if_instr !== word(32'h100 + 32'(4*k))) begin n_bad++; $display("FAIL redir_instr got %h want %h", bus.if_instr, word(32'h100 + 32'(4*k))); end
      exp_fetch++;
      tick;
    end
  endtask

  task automatic test_stall;
    bus.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h108) begin n_bad++; $display("FAIL stall_pc got %b/%h want 1/108", bus.if_valid, bus.if_pc); end
      n_cmp++; if (bus.if_instr !== word(32'h108)) begin n_bad++; $display("FAIL stall_instr got %h want %h", bus.if_instr, word(32'h108)); end
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req got %b want 0", bus.imem_req); end
      tick;
    end
    bus.if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h108 + 32'(4*k)) begin n_bad++; $display("FAIL resume_pc got %b/%h want 1/%h", bus.if_valid, bus.if_pc, 32'h108 + 32'(4*k)); end
      exp_fetch++;
      tick;
    end
  endtask

  task automatic test_back_to_back;
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin n_bad++; $display("FAIL b2b_first got %b/%h want 0/200", bus.if_valid, bus.imem_addr); end
    tick; exp_flush++;
    redirect_pc = 32'h300; #1;
    n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h300) begin n_bad++; $display("FAIL b2b_second got %b/%h want 0/300", bus.if_valid, bus.imem_addr); end
    tick; exp_flush++;
    redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got %b want 0", bus.if_valid); end
    tick;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h300 + 32'(4*k)) begin n_bad++; $display("FAIL b2b_pc got %b/%h want 1/%h", bus.if_valid, bus.if_pc, 32'h300 + 32'(4*k)); end
      exp_fetch++;
      tick;
    end
    #1;
    n_cmp++; if (fetch_cnt !== perf(exp_fetch)) begin n_bad++; $display("FAIL b2b_fetch_cnt got %0d want %0d", fetch_cnt, perf(exp_fetch)); end
    n_cmp++; if (flush_cnt !== perf(exp_flush)) begin n_bad++; $display("FAIL b2b_flush_cnt got %0d want %0d", flush_cnt, perf(exp_flush)); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_issue got %b/%h want 0/fffffffc", bus.if_valid, bus.imem_addr); end
    tick; exp_flush++;
    redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    tick; #1;
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc got %b/%h want 1/fffffffc", bus.if_valid, bus.if_pc); end
    n_cmp++; if (bus.if_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got %h want 0", bus.if_pc_plus4); end
    exp_fetch++;
    tick; #1;
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== word(32'h0)) begin n_bad++; $display("FAIL wrap_next got %b/%h/%h want 1/0/%h", bus.if_valid, bus.if_pc, bus.if_instr, word(32'h0)); end
    exp_fetch++;
    tick;
  endtask

  task automatic test_reset_mid;
    bus.if_ready = 1'b0; #1;
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin n_bad++; $display("FAIL mid_head got %b/%h want 1/4", bus.if_valid, bus.if_pc); end
    tick; #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_full_req got %b want 0", bus.imem_req); end
    n_cmp++; if (fetch_cnt !== perf(exp_fetch)) begin n_bad++; $display("FAIL mid_fetch_cnt got %0d want %0d", fetch_cnt, perf(exp_fetch)); end
    rst_n = 1'b0; #1;
    n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst got %b/%b want 0/0", bus.if_valid, bus.imem_req); end
    n_cmp++; if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin n_bad++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", fetch_cnt, flush_cnt); end
    exp_fetch = 0; exp_flush = 0;
    tick; tick;
    rst_n = 1'b1; bus.if_ready = 1'b1; #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_restart got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    tick; tick; #1;
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== word(32'h0)) begin n_bad++; $display("FAIL mid_first got %b/%h/%h want 1/0/%h", bus.if_valid, bus.if_pc, bus.if_instr, word(32'h0)); end
  endtask

  initial begin
    bus.if_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    test_reset;
    test_stream;
    test_redirect;
    test_stall;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
